multi_cycle_digit_adder: RTL and testbench

//  Parametrised sequential adder/subtractor that adds WIDTH-bit operands DIGIT bits per clock.

---
 rtl/multi_cycle_digit_adder.sv | 134 +++++++++++++
 tb/tb_multi_cycle_digit_adder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_digit_adder.sv
// Sequential adder/subtractor: WIDTH-bit operands, DIGIT bits per clock.
// Optional macro DIGIT_ADDER_SAT_EN: saturate the sum on signed overflow.
module multi_cycle_digit_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             cout_q;
    logic             ovf_q;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dsum;
    logic             last;
    logic             c_msb;
    logic             ovf_d;
    int               idx;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy = !in_ready;
    end

    // One ripple slice over the current digit, plus merged sum word
    always_comb begin
        idx   = int'(cnt_q) * DIGIT;
        a_dig = a_q[idx +: DIGIT];
        b_dig = b_q[idx +: DIGIT];
        dsum  = {1'b0, a_dig} + {1'b0, b_dig}
              + {{DIGIT{1'b0}}, carry_q};
        last  = (cnt_q == CW'(N - 1));
        // Carry into the MSB recovered from the MSB sum bit
        c_msb = a_dig[DIGIT-1] ^ b_dig[DIGIT-1]
              ^ dsum[DIGIT-1];
        ovf_d = c_msb ^ dsum[DIGIT];
        sum_d = sum_q;
        sum_d[idx +: DIGIT] = dsum[DIGIT-1:0];
`ifdef DIGIT_ADDER_SAT_EN
        // Both operands share a sign on overflow; b_q MSB picks the rail
        if (last && ovf_d) begin
            sum_d = b_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Operand latch, digit stepping and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q   <= sum_d;
            carry_q <= dsum[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                cout_q <= dsum[DIGIT];
                ovf_q  <= ovf_d;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multi_cycle_digit_adder.sv
// Bench for multi_cycle_digit_adder: 16/4 and 8/8 instances,
// directed cases plus random ops against an arithmetic model.
module tb_multi_cycle_digit_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout, ovf, busy;

    logic        e_in_valid = 1'b0, e_in_ready;
    logic [7:0]  e_a = '0, e_b = '0;
    logic        e_cin = 1'b0, e_sub = 1'b0;
    logic        e_out_valid, e_out_ready = 1'b0;
    logic [7:0]  e_sum;
    logic        e_cout, e_ovf, e_busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_cycle_digit_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    multi_cycle_digit_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(e_in_valid), .in_ready(e_in_ready),
        .a(e_a), .b(e_b), .cin(e_cin), .sub(e_sub),
        .out_valid(e_out_valid), .out_ready(e_out_ready),
        .sum(e_sum), .cout(e_cout), .ovf(e_ovf), .busy(e_busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: signed/unsigned arithmetic on whole words
    function automatic logic [17:0] model(input int w,
                                          input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c,
                                          input logic s);
        longint mask, ye, full, res, msb;
        logic co, ov;
        mask = (longint'(1) << w) - 1;
        msb  = longint'(1) << (w - 1);
        ye   = s ? (~longint'(y) & mask) : (longint'(y) & mask);
        full = (longint'(x) & mask) + ye + longint'(s ? 1'b1 : c);
        res  = full & mask;
        co   = (full >> w) != 0;
        ov   = (((longint'(x) ^ ye) & msb) == 0)
            && (((res ^ longint'(x)) & msb) != 0);
`ifdef DIGIT_ADDER_SAT_EN
        if (ov) res = ((ye & msb) != 0) ? msb : msb - 1;
`endif
        return {co, ov, 16'(res)};
    endfunction

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts, input int hold);
        logic [17:0] m;
        int k;
        m = model(16, ta, tb_, tc, ts);
        chk("idle_ready16", 32'(in_ready), 32'(1));
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk("latency16", 32'(k), 32'(4));
        chk("sum16", 32'(sum), 32'(m[15:0]));
        chk("cout16", 32'(cout), 32'(m[17]));
        chk("ovf16", 32'(ovf), 32'(m[16]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            tick();
            chk("hold_valid16", 32'(out_valid), 32'(1));
            chk("hold_sum16", 32'(sum), 32'(m[15:0]));
            chk("hold_ready16", 32'(in_ready), 32'(0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid16", 32'(out_valid), 32'(0));
        chk("release_ready16", 32'(in_ready), 32'(1));
        chk("idle_sum16", 32'(sum), 32'(m[15:0]));
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic ts, input int hold);
        logic [17:0] m;
        int k;
        m = model(8, 16'(ta), 16'(tb_), tc, ts);
        chk("idle_ready8", 32'(e_in_ready), 32'(1));
        e_a = ta; e_b = tb_; e_cin = tc; e_sub = ts; e_in_valid = 1'b1;
        tick();
        e_in_valid = 1'b0; e_a = 8'($urandom); e_b = 8'($urandom);
        k = 0;
        while (!e_out_valid && k < 20) begin
            tick();
            k++;
        end
        chk("latency8", 32'(k), 32'(1));
        chk("sum8", 32'(e_sum), 32'(m[7:0]));
        chk("cout8", 32'(e_cout), 32'(m[17]));
        chk("ovf8", 32'(e_ovf), 32'(m[16]));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_sum8", 32'(e_sum), 32'(m[7:0]));
            chk("hold_ready8", 32'(e_in_ready), 32'(0));
        end
        e_out_ready = 1'b1;
        tick();
        e_out_ready = 1'b0;
        chk("release_valid8", 32'(e_out_valid), 32'(0));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_ready", 32'(in_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        tick();

        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        op16(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        op16(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        op16(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 5);

        // Reset in the second RUN cycle discards the op
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; cin = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_valid", 32'(out_valid), 32'(0));
        chk("mrst_sum", 32'(sum), 32'(0));
        chk("mrst_ready", 32'(in_ready), 32'(1));
        op16(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

        op8(8'h80, 8'h80, 1'b0, 1'b0, 0);
        op8(8'h7F, 8'h01, 1'b0, 1'b0, 2);
        op8(8'h10, 8'h20, 1'b0, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 30; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
